mdu_iter: RTL and testbench



---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_iter.sv | 149 ++++++++++++++
 tb/tb_mdu_iter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: op encodings,
// FSM state encoding, iteration count and the divide-by-zero quotient.
package mdu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit producing the HI/LO special registers.
// One shared accumulator: shift-add multiply (LSB first) or restoring
// divide (MSB first), 32 iterations, sign fix-up in a final cycle.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op        launch MULTU/MULT/DIVU/DIV (sampled only when idle)
//   a, b             rs / rt operands
//   hi_we, lo_we     MTHI / MTLO write enables (honoured only when idle)
//   wdata            MTHI / MTLO data
//   busy             operation in flight
//   done             one-cycle pulse when an operation updates HI/LO
//   hi, lo           HI / LO registers
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned ITER_N = ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(ITER_N);
  localparam int unsigned AW = 2 * WIDTH + 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             div_q;
  logic             neg_res;
  logic             neg_rem;
  logic             div0;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_raw;
  // Multiply: acc[2W-1:0] = {partial product, remaining multiplier bits}.
  // Divide:   acc[2W:W] = remainder (W+1 bits), acc[W-1:0] = dividend/quotient.
  logic [AW-1:0]    acc;

  logic             signed_op;
  logic             div_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand decode and absolute values at launch
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div_op    = (op == OP_DIVU) || (op == OP_DIV);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_abs     = a_neg ? WIDTH'(-a) : a;
    b_abs     = b_neg ? WIDTH'(-b) : b;
  end

  // One iteration step for each mode, plus final sign fix-up
  always_comb begin
    mul_sum   = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
    // Remainder is always below the divisor, so its top bit can be dropped on shift
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = ~div_diff[WIDTH];
    prod_fix  = neg_res ? (2*WIDTH)'(-acc[2*WIDTH-1:0]) : acc[2*WIDTH-1:0];
    quot_fix  = neg_res ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? WIDTH'(-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      opnd    <= '0;
      a_raw   <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            div_q   <= div_op;
            a_raw   <= a;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= div_op & (b == '0);
            opnd    <= div_op ? b_abs : a_abs;
            acc     <= {(WIDTH+1)'(0), (div_op ? a_abs : b_abs)};
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (div_q) begin
            acc <= {(div_ge ? div_diff : div_shift), acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= {1'b0, mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER_N - 1)) state <= FIN;
        end
        FIN: begin
          if (div0) begin
            lo <= WIDTH'(DIV0_QUOT);
            hi <= a_raw;
          end else if (div_q) begin
            lo <= quot_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases with literal results,
// then randomized traffic compared every cycle against a behavioural model.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  mdu_iter #(.WIDTH(32), .ITER_N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} of one operation
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      OP_MULTU: p = {32'b0, x} * {32'b0, y};
      OP_MULT:  p = 64'(sx * sy);
      OP_DIVU:  p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Transaction-level model: an accepted op completes 33 edges later
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_left = 0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start) begin
          m_pend = ref_result(op, a, b);
          m_left = 33;
          m_busy = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      if (busy && done) chk("busy_and_done", 64'(1), 64'(0));
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; reports busy cycles seen since launch
  task automatic wait_done(output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = busy ? 1 : 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) busy_cycles++;
    end
    if (n >= 40) chk("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_lit(input string nm, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int bc;
    launch(o, x, y);
    wait_done(bc);
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(33));
    chk({nm, "_hi"}, 64'(hi), 64'(ehi));
    chk({nm, "_lo"}, 64'(lo), 64'(elo));
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    int dcnt;
    logic [31:0] lo_keep;

    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-computed results
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    chk("multu_busy_cycles", 64'(bc), 64'(33));
    chk("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);
    chk("multu_done_on", 64'(done), 64'(1));
    @(negedge clk);
    chk("multu_done_off", 64'(done), 64'(0));

    run_lit("mult_neg",  OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_lit("mult_nn",   OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd0, 32'd25);
    run_lit("divu",      OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_lit("div_neg",   OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_lit("div_zero",  OP_DIV, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
    run_lit("div_ovf",   OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // Idle MTHI leaves LO alone
    lo_keep = lo;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h0000_0000_0000_ABCD);
    chk("mthi_lo", 64'(lo), 64'(lo_keep));

    // Second start and MTLO during an operation are ignored
    launch(OP_MULTU, 32'd3, 32'd4);
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3; lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    wait_done(bc);
    chk("busy_ign_hi", 64'(hi), 64'(0));
    chk("busy_ign_lo", 64'(lo), 64'(12));
    @(negedge clk);
    chk("busy_ign_no_restart", 64'(busy), 64'(0));

    // Reset in the middle of a divide
    launch(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'(0));
    run_lit("after_abort", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14);

    // Randomized traffic, checked every cycle by the model comparison
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = rand_val();
      b     = ($urandom_range(0, 7) == 0) ? 32'h0 : rand_val();
      hi_we = ($urandom_range(0, 5) == 0);
      lo_we = ($urandom_range(0, 5) == 0);
      wdata = $urandom;
    end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) @(negedge clk);
    chk("drain_idle", 64'(busy), 64'(0));

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
